mul_result_buffer: RTL
======================

# mul_result_buffer

Two-entry result buffer between the 32-bit signed combinational multiplier and the register-file writeback port. It captures the multiplier's truncated 32-bit product, its overflow flag and the destination register index through a valid/ready handshake. It releases them in order to writeback, suppressing the register write for overflowed results. It also raises a registered trap pulse and keeps sticky and counting overflow status for software.

## Interface
- DATA_W, 32, result width (multiplier Out width)
- REG_W, 5, destination register index width
- CNT_W, 8, overflow event counter width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  multiplier result present this cycle
- in_ready  out  1  buffer can accept; depends only on occupancy (registered state)
- in_result  in  DATA_W  multiplier Out (low 32 bits of product)
- in_overflow  in  1  multiplier Overflow
- in_rd  in  REG_W  destination register index
- out_valid  out  1  head entry present
- out_ready  in  1  writeback accepts head
- out_result  out  DATA_W  head result
- out_rd  out  REG_W  head destination index
- out_we  out  1  register write enable = out_valid & ~head overflow
- trap_valid  out  1  one-cycle registered pulse: an overflowed entry was dequeued
- trap_rd  out  REG_W  destination index of that entry, held until next trap
- ovf_sticky  out  1  set on any accepted overflowed entry
- ovf_count  out  CNT_W  saturating count of accepted overflowed entries
- clr_status  in  1  clears ovf_sticky and ovf_count

## Operation
- Storage: 2 entries {result, overflow, rd}, read pointer, write pointer (1 bit each), occupancy 0..2.
- Enqueue when in_valid & in_ready; dequeue when out_valid & out_ready. Strict FIFO order.
- in_ready = (occupancy != 2). out_valid = (occupancy != 0).
- When empty: out_result, out_rd, out_we driven 0.
- Simultaneous enqueue and dequeue at occupancy 1: occupancy stays 1, both pointers advance. At occupancy 2 no enqueue occurs (in_ready=0) even if out_ready=1 that cycle.
- Overflowed entries are still buffered and delivered (out_valid=1, out_we=0) so writeback retires the slot in order.
- trap_valid next cycle = dequeue & head overflow; trap_rd loads head rd on that event, else holds.
- ovf_sticky: set on enqueue with in_overflow=1; cleared by clr_status; set wins if both in same cycle.
- ovf_count: +1 on overflowed enqueue, saturates at 2^CNT_W−1; clr_status loads 0, or 1 if an overflowed enqueue occurs the same cycle.
- in_* values sampled only when enqueued; otherwise ignored (may be X).

## Timing
- Reset (asynchronous, rst_n low): occupancy 0, pointers 0, entries 0, in_ready=1, out_valid=0, out_result=0, out_rd=0, out_we=0, trap_valid=0, trap_rd=0, ovf_sticky=0, ovf_count=0. Reset mid-operation discards buffered entries; no trap emitted for them.
- Latency: entry accepted at edge N appears on out_* after edge N, i.e. out_valid=1 in cycle N+1. No combinational in→out path.
- Throughput: 1 entry/cycle sustained when out_ready held 1.
- trap_valid asserted exactly one cycle, in the cycle after the dequeue edge.
- ovf_sticky/ovf_count update on the enqueue edge, visible the following cycle.
- out_* stable while out_valid=1 and out_ready=0.

## Test plan
- Reset then single enqueue {0x0000_0006, ovf=0, rd=3}, out_ready=1 -> next cycle out_valid=1, out_result=6, out_rd=3, out_we=1; following cycle out_valid=0, trap_valid=0.
- Overflow entry {0x0000_0000, ovf=1, rd=9} dequeued -> out_we=0 while valid; trap_valid=1 one cycle later with trap_rd=9; ovf_sticky=1, ovf_count=1.
- out_ready=0, enqueue A=0x11, B=0x22, offer C=0x33 -> in_ready=0 after B, C not taken; release out_ready -> A then B in order, in_ready returns 1 after first dequeue.
- Occupancy 1, simultaneous enqueue and dequeue for 10 cycles of streaming values 1..10 -> outputs 1..10 in order, occupancy stays 1, no loss.
- 300 overflowed enqueues with CNT_W=8 -> ovf_count=255 saturated; clr_status with same-cycle overflowed enqueue -> ovf_count=1, ovf_sticky=1.
- rst_n pulled low with 2 entries held -> immediately out_valid=0, in_ready=1, all status 0, no trap pulse after release.

Source files
------------

// File: rtl/mul_result_buffer_if.sv
// Handshake and status bundle between the multiplier/writeback side (master)
// and the two-entry result buffer (slave).
interface mul_result_buffer_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_overflow;
    logic [REG_W-1:0]  in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [REG_W-1:0]  out_rd;
    logic              out_we;
    logic              trap_valid;
    logic [REG_W-1:0]  trap_rd;
    logic              ovf_sticky;
    logic [CNT_W-1:0]  ovf_count;
    logic              clr_status;

    modport master (
        output in_valid, in_result, in_overflow, in_rd, out_ready, clr_status,
        input  in_ready, out_valid, out_result, out_rd, out_we,
               trap_valid, trap_rd, ovf_sticky, ovf_count
    );

    modport slave (
        input  in_valid, in_result, in_overflow, in_rd, out_ready, clr_status,
        output in_ready, out_valid, out_result, out_rd, out_we,
               trap_valid, trap_rd, ovf_sticky, ovf_count
    );
endinterface

// File: rtl/mul_result_buffer.sv
// Two-entry in-order buffer for multiplier results; accepted at edge N, visible on out_* in cycle N+1.
// Backpressure: in_ready drops only when both entries are held; overflowed results drain with out_we=0.
module mul_result_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_result_buffer_if.slave io_bus
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              ovf;
        logic [REG_W-1:0]  rd;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t           r_mem [2];
    logic             r_rptr;
    logic             r_wptr;
    logic [1:0]       r_occ;
    logic             r_trap_vld;
    logic [REG_W-1:0] r_trap_rd;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    entry_t w_head;
    logic   w_out_vld;
    logic   w_in_rdy;
    logic   w_enq;
    logic   w_deq;
    logic   w_enq_ovf;

    assign w_head    = r_mem[r_rptr];
    assign w_out_vld = (r_occ != 2'd0);
    assign w_in_rdy  = (r_occ != 2'd2);
    assign w_enq     = io_bus.in_valid & w_in_rdy;
    assign w_deq     = w_out_vld & io_bus.out_ready;
    assign w_enq_ovf = w_enq & io_bus.in_overflow;

    // Head fields are gated so an empty buffer presents all-zero outputs.
    assign io_bus.in_ready   = w_in_rdy;
    assign io_bus.out_valid  = w_out_vld;
    assign io_bus.out_result = w_out_vld ? w_head.result : '0;
    assign io_bus.out_rd     = w_out_vld ? w_head.rd : '0;
    assign io_bus.out_we     = w_out_vld & ~w_head.ovf;
    assign io_bus.trap_valid = r_trap_vld;
    assign io_bus.trap_rd    = r_trap_rd;
    assign io_bus.ovf_sticky = r_sticky;
    assign io_bus.ovf_count  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_rptr     <= 1'b0;
            r_wptr     <= 1'b0;
            r_occ      <= 2'd0;
            r_trap_vld <= 1'b0;
            r_trap_rd  <= '0;
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wptr] <= entry_t'{result: io_bus.in_result,
                                          ovf:    io_bus.in_overflow,
                                          rd:     io_bus.in_rd};
                r_wptr <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end

            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            r_trap_vld <= w_deq & w_head.ovf;
            if (w_deq & w_head.ovf) begin
                r_trap_rd <= w_head.rd;
            end

            // A same-cycle overflowed enqueue beats the clear.
            if (w_enq_ovf) begin
                r_sticky <= 1'b1;
            end else if (io_bus.clr_status) begin
                r_sticky <= 1'b0;
            end

            if (io_bus.clr_status) begin
                r_cnt <= w_enq_ovf ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            end else if (w_enq_ovf && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule
